// File: rtl/global_types.sv
// Shared FP types: rounding modes, operand classes, status-flag bit positions
// and width-parametrised special-value constructors.
package global_types;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } rounding_mode;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    INF  = 2'd1,
    NAN  = 2'd2,
    NORM = 2'd3
  } fp_class_t;

  localparam int unsigned FLAG_W    = 6;
  localparam int unsigned ZERO_B    = 0;
  localparam int unsigned INF_B     = 1;
  localparam int unsigned NAN_B     = 2;
  localparam int unsigned TINY_B    = 3;
  localparam int unsigned HUGE_B    = 4;
  localparam int unsigned INEXACT_B = 5;

  // Constructors return a wide vector; callers truncate to their data width.
  localparam int unsigned FN_W = 128;

  function automatic logic [FN_W-1:0] fp_qnan(input int unsigned exp_w,
                                              input int unsigned man_w);
    logic [FN_W-1:0] one;
    one = FN_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

  function automatic logic [FN_W-1:0] fp_maxn(input int unsigned exp_w,
                                              input int unsigned man_w,
                                              input logic        s);
    logic [FN_W-1:0] one;
    one = FN_W'(1);
    return (FN_W'(s) << (exp_w + man_w))
         | (((one << exp_w) - FN_W'(2)) << man_w)
         | ((one << man_w) - one);
  endfunction

  function automatic logic [FN_W-1:0] fp_minn(input int unsigned exp_w,
                                              input int unsigned man_w,
                                              input logic        s);
    logic [FN_W-1:0] one;
    one = FN_W'(1);
    return (FN_W'(s) << (exp_w + man_w)) | (one << man_w);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies an operand magnitude (sign stripped) as ZERO/INF/NAN/NORM;
// denormals are flushed to ZERO.
module fp_classify
  import global_types::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output fp_class_t              cls_c
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = mag[EXP_W+MAN_W-1:MAN_W];
  assign man_f = mag[MAN_W-1:0];

  always_comb begin
    cls_c = NORM;
    if (exp_f == '0)
      cls_c = ZERO;
    else if (&exp_f)
      cls_c = (man_f == '0) ? INF : NAN;
  end

endmodule

// File: rtl/fp_exc_pipe.sv
// Multiplier exception stage: IEEE special-case result selection behind a
// one-deep valid/ready output register, with sticky flags and an event counter.
module fp_exc_pipe
  import global_types::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [EXP_W+MAN_W:0]   z_calc,
  input  logic                   overflow,
  input  logic                   underflow,
  input  logic                   inexact,
  input  logic [2:0]             rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   zero_f,
  output logic                   inf_f,
  output logic                   nan_f,
  output logic                   tiny_f,
  output logic                   huge_f,
  output logic                   inexact_f,
  input  logic                   clr_sticky,
  output logic [5:0]             sticky_f,
  output logic [CNT_W-1:0]       exc_count
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [FLAG_W-1:0] EXC_MASK =
    FLAG_W'((1 << NAN_B) | (1 << INF_B) | (1 << HUGE_B) | (1 << TINY_B));

  fp_class_t    cls_a, cls_b;
  rounding_mode rm;
  logic         s;
  logic         accept;
  logic [W-1:0] inf_s, zero_s, maxn_s, minn_s;
  logic [W-1:0] z_sel;
  logic [FLAG_W-1:0] f_sel;
  logic         unused_sign;

  // Operand signs are irrelevant here: the result sign comes from z_calc.
  assign unused_sign = a[W-1] ^ b[W-1];

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.mag(a[W-2:0]), .cls_c(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.mag(b[W-2:0]), .cls_c(cls_b));

  assign in_ready = rst | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign s      = z_calc[W-1];
  assign rm     = rounding_mode'(rnd);
  assign inf_s  = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_s = {s, {(W-1){1'b0}}};
  assign maxn_s = W'(fp_maxn(EXP_W, MAN_W, s));
  assign minn_s = W'(fp_minn(EXP_W, MAN_W, s));

  // Priority-ordered special-case selection.
  always_comb begin
    z_sel = z_calc;
    f_sel = '0;
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO)) begin
      z_sel        = QNAN;
      f_sel[NAN_B] = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      z_sel         = inf_s;
      f_sel[INF_B]  = 1'b1;
      f_sel[HUGE_B] = 1'b1;
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      z_sel         = zero_s;
      f_sel[ZERO_B] = 1'b1;
    end else if (overflow) begin
      f_sel[HUGE_B]    = 1'b1;
      f_sel[INEXACT_B] = 1'b1;
      z_sel            = maxn_s;
      case (rm)
        IEEE_near, near_up, away_zero: begin
          z_sel        = inf_s;
          f_sel[INF_B] = 1'b1;
        end
        IEEE_pinf: if (!s) begin
          z_sel        = inf_s;
          f_sel[INF_B] = 1'b1;
        end
        IEEE_ninf: if (s) begin
          z_sel        = inf_s;
          f_sel[INF_B] = 1'b1;
        end
        default: z_sel = maxn_s;
      endcase
    end else if (underflow) begin
      f_sel[TINY_B]    = 1'b1;
      f_sel[INEXACT_B] = 1'b1;
      z_sel            = minn_s;
      case (rm)
        IEEE_near, near_up, IEEE_zero: begin
          z_sel         = zero_s;
          f_sel[ZERO_B] = 1'b1;
        end
        IEEE_pinf: if (s) begin
          z_sel         = zero_s;
          f_sel[ZERO_B] = 1'b1;
        end
        IEEE_ninf: if (!s) begin
          z_sel         = zero_s;
          f_sel[ZERO_B] = 1'b1;
        end
        default: z_sel = minn_s;
      endcase
    end else begin
      f_sel[INEXACT_B] = inexact;
      f_sel[ZERO_B]    = (z_calc[W-2:0] == '0);
    end
  end

  // Output register, sticky accumulation and saturating event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      zero_f    <= 1'b0;
      inf_f     <= 1'b0;
      nan_f     <= 1'b0;
      tiny_f    <= 1'b0;
      huge_f    <= 1'b0;
      inexact_f <= 1'b0;
      sticky_f  <= '0;
      exc_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        z         <= z_sel;
        zero_f    <= f_sel[ZERO_B];
        inf_f     <= f_sel[INF_B];
        nan_f     <= f_sel[NAN_B];
        tiny_f    <= f_sel[TINY_B];
        huge_f    <= f_sel[HUGE_B];
        inexact_f <= f_sel[INEXACT_B];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_sticky)
        sticky_f <= accept ? f_sel : '0;
      else if (accept)
        sticky_f <= sticky_f | f_sel;

      if (accept && (|(f_sel & EXC_MASK)) && (exc_count != '1))
        exc_count <= exc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_exc_pipe.sv
// Directed bench for fp_exc_pipe: special-case selection, handshake stalls,
// sticky flags and counter saturation (second instance with CNT_W=2).
module tb_fp_exc_pipe;
  import global_types::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, clr_sticky;
  logic [31:0] a, b, z_calc, z;
  logic        overflow, underflow, inexact;
  logic [2:0]  rnd;
  logic        zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f;
  logic [5:0]  sticky_f;
  logic [15:0] exc_count;

  logic        in_ready2, out_valid2;
  logic [31:0] z2;
  logic        zero_f2, inf_f2, nan_f2, tiny_f2, huge_f2, inexact_f2;
  logic [5:0]  sticky_f2;
  logic [1:0]  exc_count2;

  int checks = 0;
  int errors = 0;
  logic [31:0] delivered[$];

  always #5 clk = ~clk;

  fp_exc_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .z_calc(z_calc), .overflow(overflow), .underflow(underflow),
    .inexact(inexact), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .zero_f(zero_f), .inf_f(inf_f), .nan_f(nan_f), .tiny_f(tiny_f),
    .huge_f(huge_f), .inexact_f(inexact_f), .clr_sticky(clr_sticky),
    .sticky_f(sticky_f), .exc_count(exc_count)
  );

  fp_exc_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .z_calc(z_calc), .overflow(overflow), .underflow(underflow),
    .inexact(inexact), .rnd(rnd), .out_valid(out_valid2), .out_ready(out_ready),
    .z(z2), .zero_f(zero_f2), .inf_f(inf_f2), .nan_f(nan_f2), .tiny_f(tiny_f2),
    .huge_f(huge_f2), .inexact_f(inexact_f2), .clr_sticky(clr_sticky),
    .sticky_f(sticky_f2), .exc_count(exc_count2)
  );

  // Record every completed output transfer.
  always @(posedge clk)
    if (!rst && out_valid && out_ready) delivered.push_back(z);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f};
  endfunction

  // One beat presented at the negedge, accepted at the next posedge.
  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] zz,
                      input logic ov, input logic un, input logic ix, input rounding_mode rm);
    @(negedge clk);
    a = aa; b = bb; z_calc = zz; overflow = ov; underflow = un; inexact = ix; rnd = rm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic beat_chk(input string tag, input logic [31:0] ez, input logic [5:0] ef);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_z"}, 64'(z), 64'(ez));
    chk({tag, "_flags"}, 64'(flags()), 64'(ef));
  endtask

  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;
  rounding_mode ov_modes[6] = '{IEEE_near, near_up, away_zero, IEEE_ninf, IEEE_zero, IEEE_pinf};
  logic [31:0]  ov_z[6]     = '{32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000,
                                32'hFF7FFFFF, 32'hFF7FFFFF};
  logic [5:0]   ov_f[6]     = '{6'b110010, 6'b110010, 6'b110010, 6'b110010,
                                6'b110000, 6'b110000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    a = '0; b = '0; z_calc = '0; overflow = 1'b0; underflow = 1'b0; inexact = 1'b0;
    rnd = IEEE_near;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_sticky", 64'(sticky_f), 64'd0);
    chk("rst_count", 64'(exc_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;

    // Plain passthrough
    send(ONE, TWO, TWO, 1'b0, 1'b0, 1'b0, IEEE_near);
    beat_chk("pass", TWO, 6'b000000);

    // NaN cases
    send(32'h7FC00001, ONE, ONE, 1'b0, 1'b0, 1'b0, IEEE_near);
    beat_chk("nan_op", 32'h7FC00000, 6'b000100);
    send(32'h00000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1'b0, IEEE_near);
    beat_chk("zero_inf", 32'h7FC00000, 6'b000100);
    chk("count_nan", 64'(exc_count), 64'd2);

    // INF x NORM and denormal x NORM
    send(32'h7F800000, ONE, 32'h80000000, 1'b0, 1'b0, 1'b0, IEEE_near);
    beat_chk("inf_norm", 32'hFF800000, 6'b010010);
    send(32'h00000001, ONE, 32'h80000000, 1'b0, 1'b0, 1'b0, IEEE_near);
    beat_chk("denorm_norm", 32'h80000000, 6'b000001);

    // Overflow, negative sign, all six modes
    for (int i = 0; i < 6; i++) begin
      send(ONE, TWO, 32'hC0000000, 1'b1, 1'b1, 1'b0, ov_modes[i]);
      beat_chk($sformatf("ovf_%s", ov_modes[i].name()), ov_z[i], ov_f[i]);
    end
    chk("count_ovf", 64'(exc_count), 64'd9);

    // Underflow, positive sign
    send(ONE, TWO, 32'h00000001, 1'b0, 1'b1, 1'b0, away_zero);
    beat_chk("unf_away", 32'h00800000, 6'b101000);
    send(ONE, TWO, 32'h00000001, 1'b0, 1'b1, 1'b0, IEEE_near);
    beat_chk("unf_near", 32'h00000000, 6'b101001);
    send(ONE, TWO, 32'h00000001, 1'b0, 1'b1, 1'b0, IEEE_ninf);
    beat_chk("unf_ninf", 32'h00000000, 6'b101001);
    send(ONE, TWO, 32'h00000001, 1'b0, 1'b1, 1'b0, IEEE_pinf);
    beat_chk("unf_pinf", 32'h00800000, 6'b101000);
    chk("count_unf", 64'(exc_count), 64'd13);

    // Backpressure: beat A captured, beat B held off for three cycles
    repeat (2) @(posedge clk);
    #1;
    delivered.delete();
    send(ONE, TWO, 32'h12345678, 1'b0, 1'b0, 1'b0, IEEE_near);
    out_ready = 1'b0;
    a = ONE; b = TWO; z_calc = 32'h23456789; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_in_ready_%0d", i), 64'(in_ready), 64'd0);
      chk($sformatf("stall_z_%0d", i), 64'(z), 64'h12345678);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    beat_chk("stall_b", 32'h23456789, 6'b000000);
    @(posedge clk);
    #1;
    chk("stall_drain_valid", 64'(out_valid), 64'd0);
    chk("stall_n_deliv", 64'(delivered.size()), 64'd2);
    if (delivered.size() == 2) begin
      chk("stall_first", 64'(delivered[0]), 64'h12345678);
      chk("stall_second", 64'(delivered[1]), 64'h23456789);
    end

    // Sticky flags
    send(ONE, TWO, TWO, 1'b0, 1'b0, 1'b1, IEEE_near);
    beat_chk("inexact_pass", TWO, 6'b100000);
    chk("sticky_accum", 64'(sticky_f[5]), 64'd1);
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_clr", 64'(sticky_f), 64'd0);
    @(negedge clk);
    clr_sticky = 1'b1;
    send(ONE, TWO, 32'hC0000000, 1'b1, 1'b0, 1'b0, IEEE_near);
    clr_sticky = 1'b0;
    chk("sticky_clr_beat", 64'(sticky_f), 64'b110010);
    send(ONE, TWO, 32'h00000001, 1'b0, 1'b1, 1'b0, away_zero);
    chk("sticky_or", 64'(sticky_f), 64'b111010);

    // Counter: five more exception beats
    for (int i = 0; i < 5; i++)
      send(ONE, TWO, 32'hC0000000, 1'b1, 1'b0, 1'b0, IEEE_near);
    chk("count_wide", 64'(exc_count), 64'd20);
    chk("count_sat", 64'(exc_count2), 64'd3);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    send(ONE, TWO, 32'h0BADBEEF, 1'b0, 1'b0, 1'b0, IEEE_near);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_comb_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_z", 64'(z), 64'd0);
    chk("midrst_sticky", 64'(sticky_f), 64'd0);
    chk("midrst_count", 64'(exc_count), 64'd0);
    chk("midrst_count2", 64'(exc_count2), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
